// File: rtl/lsu_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module  : lsu_ctrl_pkg
// Purpose : Shared definitions for the load/store controller: RISC-V funct3
//           encodings for loads and stores, controller state encodings and
//           helpers that classify an incoming access as illegal or
//           misaligned.
// Ports   : none (package)
// Rev     : 1.0 - initial release
// ============================================================================
package lsu_ctrl_pkg;

   localparam int LSU_XLEN = 32;

   // Load funct3 encodings
   localparam logic [2:0] F3_LB  = 3'b000;
   localparam logic [2:0] F3_LH  = 3'b001;
   localparam logic [2:0] F3_LW  = 3'b010;
   localparam logic [2:0] F3_LD  = 3'b011;
   localparam logic [2:0] F3_LBU = 3'b100;
   localparam logic [2:0] F3_LHU = 3'b101;
   localparam logic [2:0] F3_LWU = 3'b110;

   // Store funct3 encodings
   localparam logic [2:0] F3_SB  = 3'b000;
   localparam logic [2:0] F3_SH  = 3'b001;
   localparam logic [2:0] F3_SW  = 3'b010;
   localparam logic [2:0] F3_SD  = 3'b011;

   typedef enum logic [1:0] {
      LSU_IDLE = 2'd0,
      LSU_RD   = 2'd1,
      LSU_WR   = 2'd2,
      LSU_RESP = 2'd3
   } lsu_state_e;

   // Encodings that have no meaning on a 32-bit machine (64-bit loads/stores,
   // LWU, and the unused 111 load slot / anything above SW for stores).
   function automatic logic access_illegal(input logic       is_load,
                                           input logic [2:0] funct3);
      if (is_load) begin
         return (funct3 == F3_LD) || (funct3 == F3_LWU) || (funct3 == 3'b111);
      end
      return (funct3 > F3_SW);
   endfunction

   // funct3[1:0] is the access size for every legal encoding:
   // 00 byte, 01 halfword, 10 word.
   function automatic logic access_misaligned(input logic [1:0] size,
                                              input logic [1:0] offset);
      case (size)
         2'b01:   return offset[0];
         2'b10:   return (offset != 2'b00);
         default: return 1'b0;
      endcase
   endfunction

endpackage : lsu_ctrl_pkg
`default_nettype wire

// File: rtl/lsu_lane.sv
`default_nettype none
// ============================================================================
// Module  : lsu_lane
// Purpose : Byte-lane steering for the load/store controller. Purely
//           combinational. Extracts and extends a load value from a memory
//           word, and merges store data into a memory word for sub-word
//           stores (the memory only accepts whole-word writes).
// Ports   : word       - word read from memory
//           offset     - byte offset within the word (addr[1:0])
//           funct3     - access funct3 (interpreted as load or store code)
//           wdata      - right-aligned store data
//           load_val   - sign/zero-extended load result
//           store_word - full word to write back to memory
// Rev     : 1.0 - initial release
// ============================================================================
module lsu_lane
   import lsu_ctrl_pkg::*;
(
   input  logic [LSU_XLEN-1:0] word,
   input  logic [1:0]          offset,
   input  logic [2:0]          funct3,
   input  logic [LSU_XLEN-1:0] wdata,
   output logic [LSU_XLEN-1:0] load_val,
   output logic [LSU_XLEN-1:0] store_word
);

   logic [7:0]  byte_sel;
   logic [15:0] half_sel;

   always_comb begin
      byte_sel = word[{offset, 3'b000} +: 8];
      half_sel = word[{offset[1], 4'b0000} +: 16];

      load_val = word;
      case (funct3)
         F3_LB:   load_val = {{24{byte_sel[7]}}, byte_sel};
         F3_LH:   load_val = {{16{half_sel[15]}}, half_sel};
         F3_LBU:  load_val = {24'h000000, byte_sel};
         F3_LHU:  load_val = {16'h0000, half_sel};
         default: load_val = word;
      endcase

      // Sub-word stores keep the untouched lanes of the word just read.
      store_word = wdata;
      case (funct3)
         F3_SB: begin
            store_word = word;
            store_word[{offset, 3'b000} +: 8] = wdata[7:0];
         end
         F3_SH: begin
            store_word = word;
            store_word[{offset[1], 4'b0000} +: 16] = wdata[15:0];
         end
         default: store_word = wdata;
      endcase
   end

endmodule : lsu_lane
`default_nettype wire

// File: rtl/lsu_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : lsu_ctrl
// Purpose : Sequences loads and stores between the execute stage and a
//           single-ported, word-write-only data memory. Word-aligns the
//           memory address, extends loads, performs read-modify-write for
//           byte/halfword stores and reports misaligned or illegal accesses
//           without touching memory.
// Ports   : clock, reset            - clock / async active-high reset
//           req_valid, req_ready    - request handshake (ready only in IDLE)
//           req_is_load, req_funct3 - access kind
//           req_addr, req_wdata     - byte address and right-aligned data
//           rsp_done                - one-cycle completion pulse
//           rsp_rdata, rsp_err      - load result / error flag with rsp_done
//           mem_req, mem_we         - memory request and write enable
//           mem_addr, mem_wdata     - word address and full write word
//           mem_rdata, mem_ack      - memory read data and completion
// Rev     : 1.0 - initial release
// ============================================================================
module lsu_ctrl
   import lsu_ctrl_pkg::*;
#(
   parameter int XLEN = LSU_XLEN   // only 32 is supported
) (
   input  logic            clock,
   input  logic            reset,
   input  logic            req_valid,
   output logic            req_ready,
   input  logic            req_is_load,
   input  logic [2:0]      req_funct3,
   input  logic [XLEN-1:0] req_addr,
   input  logic [XLEN-1:0] req_wdata,
   output logic            rsp_done,
   output logic [XLEN-1:0] rsp_rdata,
   output logic            rsp_err,
   output logic            mem_req,
   output logic            mem_we,
   output logic [XLEN-1:0] mem_addr,
   output logic [XLEN-1:0] mem_wdata,
   input  logic [XLEN-1:0] mem_rdata,
   input  logic            mem_ack
);

   lsu_state_e      state;
   lsu_state_e      state_nxt;

   logic            is_load_q;
   logic [2:0]      funct3_q;
   logic [XLEN-1:0] addr_q;
   logic [XLEN-1:0] wdata_q;
   logic [XLEN-1:0] rdata_q;
   logic            err_q;

   logic            req_fault;
   logic            accept;
   logic [XLEN-1:0] load_val;
   logic [XLEN-1:0] store_word;

   assign req_fault = access_illegal(req_is_load, req_funct3)
                    | access_misaligned(req_funct3[1:0], req_addr[1:0]);
   assign accept    = (state == LSU_IDLE) && req_valid;

   // One lane unit serves both the load result and the store merge; both
   // work from the latched request and the latched read word.
   lsu_lane u_lane (
      .word       (rdata_q),
      .offset     (addr_q[1:0]),
      .funct3     (funct3_q),
      .wdata      (wdata_q),
      .load_val   (load_val),
      .store_word (store_word)
   );

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state     <= LSU_IDLE;
         is_load_q <= 1'b0;
         funct3_q  <= 3'b000;
         addr_q    <= '0;
         wdata_q   <= '0;
         rdata_q   <= '0;
         err_q     <= 1'b0;
      end else begin
         state <= state_nxt;
         if (accept) begin
            is_load_q <= req_is_load;
            funct3_q  <= req_funct3;
            addr_q    <= req_addr;
            wdata_q   <= req_wdata;
            err_q     <= req_fault;
         end
         if ((state == LSU_RD) && mem_ack) begin
            rdata_q <= mem_rdata;
         end
      end
   end

   // Every output is decoded from the registered state, so an asynchronous
   // reset drops mem_req immediately and suppresses the pending response.
   always_comb begin
      state_nxt = state;
      req_ready = 1'b0;
      rsp_done  = 1'b0;
      rsp_rdata = '0;
      rsp_err   = 1'b0;
      mem_req   = 1'b0;
      mem_we    = 1'b0;
      mem_addr  = '0;
      mem_wdata = '0;

      case (state)
         LSU_IDLE: begin
            req_ready = 1'b1;
            if (req_valid) begin
               if (req_fault) begin
                  state_nxt = LSU_RESP;
               end else if (req_is_load || (req_funct3 != F3_SW)) begin
                  state_nxt = LSU_RD;
               end else begin
                  state_nxt = LSU_WR;
               end
            end
         end

         LSU_RD: begin
            mem_req  = 1'b1;
            mem_addr = {addr_q[XLEN-1:2], 2'b00};
            if (mem_ack) begin
               state_nxt = is_load_q ? LSU_RESP : LSU_WR;
            end
         end

         LSU_WR: begin
            mem_req   = 1'b1;
            mem_we    = 1'b1;
            mem_addr  = {addr_q[XLEN-1:2], 2'b00};
            mem_wdata = store_word;
            if (mem_ack) begin
               state_nxt = LSU_RESP;
            end
         end

         LSU_RESP: begin
            rsp_done  = 1'b1;
            rsp_err   = err_q;
            rsp_rdata = (is_load_q && !err_q) ? load_val : '0;
            state_nxt = LSU_IDLE;
         end

         default: state_nxt = LSU_IDLE;
      endcase
   end

endmodule : lsu_ctrl
`default_nettype wire

// File: tb/tb_lsu_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : tb_lsu_ctrl
// Purpose : Self-checking bench for lsu_ctrl. Directed vector table for the
//           single-access cases plus hand-written sequences for memory wait
//           states, busy-time requests and mid-operation reset.
// Ports   : none
// Rev     : 1.0 - initial release
// ============================================================================
module tb_lsu_ctrl;
   import lsu_ctrl_pkg::*;

   logic        clock;
   logic        reset;
   logic        req_valid;
   logic        req_ready;
   logic        req_is_load;
   logic [2:0]  req_funct3;
   logic [31:0] req_addr;
   logic [31:0] req_wdata;
   logic        rsp_done;
   logic [31:0] rsp_rdata;
   logic        rsp_err;
   logic        mem_req;
   logic        mem_we;
   logic [31:0] mem_addr;
   logic [31:0] mem_wdata;
   logic [31:0] mem_rdata;
   logic        mem_ack;

   int checks = 0;
   int errors = 0;

   // Memory model state (written only by the responder process)
   int          read_cnt  = 0;
   int          write_cnt = 0;
   int          stab_errs = 0;
   logic [31:0] last_waddr = '0;
   logic [31:0] last_wdata = '0;
   // Written only by the test process
   int          ack_delay = 0;

   lsu_ctrl #(.XLEN(32)) dut (
      .clock       (clock),
      .reset       (reset),
      .req_valid   (req_valid),
      .req_ready   (req_ready),
      .req_is_load (req_is_load),
      .req_funct3  (req_funct3),
      .req_addr    (req_addr),
      .req_wdata   (req_wdata),
      .rsp_done    (rsp_done),
      .rsp_rdata   (rsp_rdata),
      .rsp_err     (rsp_err),
      .mem_req     (mem_req),
      .mem_we      (mem_we),
      .mem_addr    (mem_addr),
      .mem_wdata   (mem_wdata),
      .mem_rdata   (mem_rdata),
      .mem_ack     (mem_ack)
   );

   initial begin
      clock = 1'b0;
      forever #5 clock = ~clock;
   end

   initial begin
      #200000;
      $display("FAIL watchdog timeout");
      $fatal(1, "watchdog");
   end

   // Memory responder: word 0x100 reads as 0x8899AABB, writes are logged only.
   // Decides mem_ack at each falling edge for the following rising edge.
   initial begin : g_mem
      int          wait_cnt;
      bit          held;
      logic [31:0] p_addr;
      logic [31:0] p_wdata;
      logic        p_we;
      wait_cnt  = 0;
      held      = 1'b0;
      p_addr    = '0;
      p_wdata   = '0;
      p_we      = 1'b0;
      mem_ack   = 1'b0;
      mem_rdata = '0;
      forever begin
         @(negedge clock);
         if (reset || !mem_req) begin
            mem_ack  = 1'b0;
            wait_cnt = 0;
            held     = 1'b0;
         end else begin
            if (held && ((mem_addr != p_addr) || (mem_we != p_we) || (mem_wdata != p_wdata))) begin
               stab_errs++;
            end
            held    = 1'b1;
            p_addr  = mem_addr;
            p_we    = mem_we;
            p_wdata = mem_wdata;
            if (wait_cnt >= ack_delay) begin
               mem_ack  = 1'b1;
               wait_cnt = 0;
               held     = 1'b0;
               if (mem_we) begin
                  write_cnt++;
                  last_waddr = mem_addr;
                  last_wdata = mem_wdata;
               end else begin
                  read_cnt++;
                  mem_rdata = (mem_addr == 32'h100) ? 32'h8899AABB : 32'hDEADBEEF;
               end
            end else begin
               mem_ack = 1'b0;
               wait_cnt++;
            end
         end
      end
   end

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%h required=%h", nm, act, exp);
      end
   endtask

   // Issues one access in the next cycle (cycle T) and waits for rsp_done.
   // lat counts cycles after T; -1 means no response within the budget.
   task automatic run_access(input logic ld, input logic [2:0] f3,
                             input logic [31:0] a, input logic [31:0] wd,
                             input bit hold, output int lat,
                             output logic [31:0] rd, output logic er,
                             output int busy_ready, output logic post_done,
                             output logic post_ready);
      lat        = -1;
      rd         = '0;
      er         = 1'b0;
      busy_ready = 0;
      @(negedge clock);
      chk("ready_before_accept", {31'd0, req_ready}, 32'd1);
      req_valid   = 1'b1;
      req_is_load = ld;
      req_funct3  = f3;
      req_addr    = a;
      req_wdata   = wd;
      for (int n = 1; n <= 40; n++) begin
         @(negedge clock);
         if (hold) begin
            // A different, legal request kept pending while busy
            req_is_load = 1'b1;
            req_funct3  = F3_LW;
            req_addr    = 32'h100;
         end else begin
            req_valid = 1'b0;
         end
         if (rsp_done) begin
            lat = n;
            rd  = rsp_rdata;
            er  = rsp_err;
            break;
         end
         if (req_ready) busy_ready++;
      end
      req_valid = 1'b0;
      @(negedge clock);
      post_done  = rsp_done;
      post_ready = req_ready;
   endtask

   typedef struct {
      logic        ld;
      logic [2:0]  f3;
      logic [31:0] addr;
      logic [31:0] wd;
      logic [31:0] rdata;
      logic        err;
      int          lat;
      int          reads;
      int          writes;
      logic [31:0] wword;
   } vec_t;

   function automatic vec_t mkv(input logic ld, input logic [2:0] f3,
                                input logic [31:0] addr, input logic [31:0] wd,
                                input logic [31:0] rdata, input logic err,
                                input int lat, input int reads, input int writes,
                                input logic [31:0] wword);
      vec_t v;
      v.ld = ld; v.f3 = f3; v.addr = addr; v.wd = wd; v.rdata = rdata;
      v.err = err; v.lat = lat; v.reads = reads; v.writes = writes; v.wword = wword;
      return v;
   endfunction

   localparam int NV = 18;
   vec_t vt [NV];

   initial begin : g_test
      int          lat;
      logic [31:0] rd;
      logic        er;
      int          busy;
      logic        pdone;
      logic        pready;
      int          r0, w0, s0;
      bit          saw_done;
      bit          saw_req;

      // ld f3 addr wdata | rdata err lat reads writes write-word
      vt[0]  = mkv(1, F3_LB,  32'h103, 32'h0,        32'hFFFFFF88, 0, 2, 1, 0, 32'h0);
      vt[1]  = mkv(1, F3_LBU, 32'h101, 32'h0,        32'h000000AA, 0, 2, 1, 0, 32'h0);
      vt[2]  = mkv(1, F3_LH,  32'h102, 32'h0,        32'hFFFF8899, 0, 2, 1, 0, 32'h0);
      vt[3]  = mkv(1, F3_LHU, 32'h100, 32'h0,        32'h0000AABB, 0, 2, 1, 0, 32'h0);
      vt[4]  = mkv(1, F3_LW,  32'h100, 32'h0,        32'h8899AABB, 0, 2, 1, 0, 32'h0);
      vt[5]  = mkv(1, F3_LB,  32'h100, 32'h0,        32'hFFFFFFBB, 0, 2, 1, 0, 32'h0);
      vt[6]  = mkv(0, F3_SB,  32'h102, 32'h00000055, 32'h0,        0, 3, 1, 1, 32'h8855AABB);
      vt[7]  = mkv(0, F3_SH,  32'h100, 32'h00001234, 32'h0,        0, 3, 1, 1, 32'h88991234);
      vt[8]  = mkv(0, F3_SH,  32'h102, 32'hABCD1234, 32'h0,        0, 3, 1, 1, 32'h1234AABB);
      vt[9]  = mkv(0, F3_SB,  32'h101, 32'h000000FF, 32'h0,        0, 3, 1, 1, 32'h8899FFBB);
      vt[10] = mkv(0, F3_SW,  32'h100, 32'h12345678, 32'h0,        0, 2, 0, 1, 32'h12345678);
      vt[11] = mkv(1, F3_LW,  32'h102, 32'h0,        32'h0,        1, 1, 0, 0, 32'h0);
      vt[12] = mkv(0, F3_SH,  32'h101, 32'h00001234, 32'h0,        1, 1, 0, 0, 32'h0);
      vt[13] = mkv(1, F3_LD,  32'h100, 32'h0,        32'h0,        1, 1, 0, 0, 32'h0);
      vt[14] = mkv(0, F3_SD,  32'h100, 32'h0,        32'h0,        1, 1, 0, 0, 32'h0);
      vt[15] = mkv(1, F3_LH,  32'h101, 32'h0,        32'h0,        1, 1, 0, 0, 32'h0);
      vt[16] = mkv(0, F3_SW,  32'h103, 32'h0,        32'h0,        1, 1, 0, 0, 32'h0);
      vt[17] = mkv(1, F3_LWU, 32'h100, 32'h0,        32'h0,        1, 1, 0, 0, 32'h0);

      reset       = 1'b1;
      req_valid   = 1'b0;
      req_is_load = 1'b0;
      req_funct3  = 3'b000;
      req_addr    = '0;
      req_wdata   = '0;

      repeat (3) @(negedge clock);
      chk("rst_req_ready", {31'd0, req_ready}, 32'd1);
      chk("rst_rsp_done",  {31'd0, rsp_done},  32'd0);
      chk("rst_rsp_rdata", rsp_rdata,          32'd0);
      chk("rst_rsp_err",   {31'd0, rsp_err},   32'd0);
      chk("rst_mem_req",   {31'd0, mem_req},   32'd0);
      chk("rst_mem_we",    {31'd0, mem_we},    32'd0);
      chk("rst_mem_addr",  mem_addr,           32'd0);
      chk("rst_mem_wdata", mem_wdata,          32'd0);
      reset = 1'b0;

      // ---------------- Vector table, zero-wait memory ----------------
      ack_delay = 0;
      for (int i = 0; i < NV; i++) begin
         r0 = read_cnt; w0 = write_cnt; s0 = stab_errs;
         run_access(vt[i].ld, vt[i].f3, vt[i].addr, vt[i].wd, 1'b0,
                    lat, rd, er, busy, pdone, pready);
         chk($sformatf("v%0d_rdata", i),  rd,                 vt[i].rdata);
         chk($sformatf("v%0d_err", i),    {31'd0, er},        {31'd0, vt[i].err});
         chk($sformatf("v%0d_latency", i), lat,               vt[i].lat);
         chk($sformatf("v%0d_reads", i),  read_cnt - r0,      vt[i].reads);
         chk($sformatf("v%0d_writes", i), write_cnt - w0,     vt[i].writes);
         chk($sformatf("v%0d_busy_ready", i), busy,           32'd0);
         chk($sformatf("v%0d_done_width", i), {31'd0, pdone}, 32'd0);
         chk($sformatf("v%0d_ready_after", i), {31'd0, pready}, 32'd1);
         chk($sformatf("v%0d_stability", i), stab_errs - s0,  32'd0);
         if (vt[i].writes != 0) begin
            chk($sformatf("v%0d_waddr", i), last_waddr, 32'h100);
            chk($sformatf("v%0d_wdata", i), last_wdata, vt[i].wword);
         end
      end

      // ------------- SB with 3 wait cycles on read and write ----------
      // Request input held valid (as a LW) for the whole busy period.
      ack_delay = 3;
      r0 = read_cnt; w0 = write_cnt; s0 = stab_errs;
      run_access(1'b0, F3_SB, 32'h102, 32'h00000055, 1'b1,
                 lat, rd, er, busy, pdone, pready);
      chk("slow_sb_latency",    lat,             32'd9);
      chk("slow_sb_rdata",      rd,              32'd0);
      chk("slow_sb_err",        {31'd0, er},     32'd0);
      chk("slow_sb_busy_ready", busy,            32'd0);
      chk("slow_sb_reads",      read_cnt - r0,   32'd1);
      chk("slow_sb_writes",     write_cnt - w0,  32'd1);
      chk("slow_sb_wdata",      last_wdata,      32'h8855AABB);
      chk("slow_sb_stability",  stab_errs - s0,  32'd0);
      chk("slow_sb_ready_after", {31'd0, pready}, 32'd1);

      // ------------- Reset in the second WR wait cycle -----------------
      ack_delay = 3;
      r0 = read_cnt; w0 = write_cnt;
      saw_done = 1'b0;
      saw_req  = 1'b0;
      @(negedge clock);
      req_valid   = 1'b1;
      req_is_load = 1'b0;
      req_funct3  = F3_SB;
      req_addr    = 32'h102;
      req_wdata   = 32'h00000055;
      for (int n = 1; n <= 6; n++) begin
         @(negedge clock);
         req_valid = 1'b0;
         if (rsp_done) saw_done = 1'b1;
      end
      chk("mid_mem_req", {31'd0, mem_req}, 32'd1);
      chk("mid_mem_we",  {31'd0, mem_we},  32'd1);
      #2 reset = 1'b1;
      #1;
      chk("async_mem_req_drop", {31'd0, mem_req},   32'd0);
      chk("async_ready",        {31'd0, req_ready}, 32'd1);
      @(negedge clock);
      reset = 1'b0;
      for (int n = 0; n < 5; n++) begin
         @(negedge clock);
         if (rsp_done) saw_done = 1'b1;
         if (mem_req)  saw_req  = 1'b1;
      end
      chk("abort_no_done",    {31'd0, saw_done},  32'd0);
      chk("abort_no_mem_req", {31'd0, saw_req},   32'd0);
      chk("abort_ready",      {31'd0, req_ready}, 32'd1);
      chk("abort_reads",      read_cnt - r0,      32'd1);
      chk("abort_writes",     write_cnt - w0,     32'd0);

      ack_delay = 0;
      r0 = read_cnt;
      run_access(1'b1, F3_LW, 32'h100, 32'h0, 1'b0,
                 lat, rd, er, busy, pdone, pready);
      chk("post_rst_lw_rdata",   rd,            32'h8899AABB);
      chk("post_rst_lw_err",     {31'd0, er},   32'd0);
      chk("post_rst_lw_latency", lat,           32'd2);
      chk("post_rst_lw_reads",   read_cnt - r0, 32'd1);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule : tb_lsu_ctrl
`default_nettype wire

// File: doc/lsu_ctrl.md
Name: lsu_ctrl

Overview:
- Sequences every load/store between the execute stage and the single-ported data memory.
- Word-aligns addresses and sign/zero-extends loads.
- Does a read-modify-write for sub-word stores, because the memory supports whole-word writes only.
- Detects misaligned accesses and reports them without touching memory.

Parameters:
- XLEN, 32, data/address width; only 32 is supported.

Ports:
- clock  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-high reset
- req_valid  in  1  execute stage presents an access
- req_ready  out  1  controller can accept an access (high only in IDLE)
- req_is_load  in  1  1 = load, 0 = store
- req_funct3  in  3  RISC-V funct3: LB/LH/LW/LBU/LHU, SB/SH/SW per defines.vh
- req_addr  in  XLEN  byte address
- req_wdata  in  XLEN  store data, right-aligned
- rsp_done  out  1  one-cycle pulse at completion
- rsp_rdata  out  XLEN  extended load result, valid with rsp_done
- rsp_err  out  1  misaligned or illegal funct3, valid with rsp_done
- mem_req  out  1  memory request
- mem_we  out  1  1 = write
- mem_addr  out  XLEN  word address, bits [1:0] always 0
- mem_wdata  out  XLEN  full write word
- mem_rdata  in  XLEN  read word, valid when mem_ack is high on a read
- mem_ack  in  1  completes the current request; ignored while mem_req is low

Behaviour:
- Reset values: state IDLE, req_ready=1, rsp_done=0, rsp_rdata=0, rsp_err=0, mem_req=0, mem_we=0, mem_addr=0, mem_wdata=0.
- Reset asserted mid-operation: abort immediately; mem_req drops asynchronously; no response is issued for the aborted access.
- Accept: in IDLE, req_valid=1 latches is_load, funct3, addr, wdata. A request is accepted only in IDLE.
- Misaligned access: H/HU with addr[0]=1, or W with addr[1:0]!=0.
- Illegal access: load funct3 011, 110 or 111, or store funct3 above 010.
- States and transitions:
  - IDLE -> RESP (rsp_err=1) when the access is misaligned or illegal.
  - IDLE -> RD for a load, SB or SH.
  - IDLE -> WR for SW.
  - RD: mem_req=1, mem_we=0, mem_addr={addr[31:2],2'b00}. Wait for mem_ack, then latch mem_rdata. Go to RESP if load, WR if store.
  - WR: mem_req=1, mem_we=1. mem_wdata = latched read word with only the addressed lanes replaced: SB at byte addr[1:0], SH at halfword addr[1]. For SW, mem_wdata = wdata. Wait for mem_ack, then go to RESP.
  - RESP: rsp_done=1 for exactly one cycle; rsp_rdata/rsp_err held stable that cycle. Next state IDLE.
- Load extraction:
  - byte = word[8*addr[1:0] +: 8]
  - half = word[16*addr[1] +: 16]
  - LB/LH sign-extend, LBU/LHU zero-extend, LW passes the word through.
- Stores: rsp_rdata=0.
- mem_req, mem_we, mem_addr and mem_wdata stay constant from assertion until the mem_ack cycle inclusive. mem_req falls the cycle after the ack.
- mem_ack is accepted in the same cycle mem_req rises.
- Latency with zero-wait memory (accept cycle T):
  - load: rsp_done at T+2
  - SW: rsp_done at T+2
  - SB/SH: rsp_done at T+3
  - error: rsp_done at T+1
- Each memory wait cycle adds one cycle.
- Back-to-back: req_ready returns high the cycle after RESP. There is no accept during RESP.

Decomposition:
- defines.vh already holds the funct3 encodings (LB..LWU, SB..SD).
- Add state encodings LSU_IDLE/RD/WR/RESP there.
- Natural sub-module: lsu_lane, purely combinational. Inputs: word, offset, funct3, wdata. Outputs: extended load value and merged store word. It is shared by the RD->RESP and WR paths and is unit-testable alone.

Test Plan:
- Memory 0x100=0x8899AABB, zero-wait. LB 0x103 -> rdata 0xFFFFFF88. LBU 0x101 -> 0x000000AA. LH 0x102 -> 0xFFFF8899. LHU 0x100 -> 0x0000AABB. Each gives rsp_done at T+2.
- SB 0x102 wdata 0x00000055 -> one read of 0x100, then a write of 0x8855AABB; rsp_done at T+3. SH 0x100 wdata 0x1234 -> write 0x88991234.
- SW 0x100 wdata 0x12345678 -> no read cycle; a single write of 0x12345678 to 0x100; rsp_done at T+2.
- LW 0x102 and SH 0x101 -> rsp_err=1 at T+1, mem_req never asserted. Load funct3=011 -> rsp_err=1.
- mem_ack delayed 3 cycles on both the read and the write of an SB -> mem_addr/mem_wdata stable throughout; rsp_done at T+9; req_valid held high during busy is not accepted.
- Reset asserted in the second WR wait cycle -> mem_req=0 in the same cycle; no rsp_done; req_ready=1 after release; the next LW 0x100 completes normally.
